// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the CPU control path: opcode and phase encodings used by sequencer and ALU.
// Pure declarations, no state.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(3'(p) + 3'd1);
    endfunction

    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath bundle: opcode/zero in, phase and control strobes out.
// master = sequencer, slave = datapath side.
interface cpu_sequencer_if;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] phase;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       halt;
    logic       ld_pc;
    logic       data_e;
    logic       ld_ac;
    logic       wr;

    modport master (
        input  opcode, zero,
        output phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
    );

    modport slave (
        output opcode, zero,
        input  phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
    );
endinterface

// File: rtl/cpu_sequencer_phase_counter.sv
// Eight-phase instruction counter that freezes at OP_ADDR once a HLT is executed.
// Phase and halted flag update one clk after the condition; only rst leaves the halted state.
module phase_counter
    import cpu_sequencer_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  opcode_t opcode,
    output phase_t  phase,
    output logic    halted
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= INST_ADDR;
            halted <= 1'b0;
        end else if (!halted) begin
            // Phase is compared first so a don't-care opcode outside OP_ADDR cannot reach halted
            if (phase == OP_ADDR && opcode == HLT) begin
                halted <= 1'b1;
            end else begin
                phase <= next_phase(phase);
            end
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Control sequencer: phase counter plus combinational decode of phase/opcode/zero into datapath strobes.
// Controls follow the phase register with zero-cycle decode latency.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    cpu_sequencer_if.master  bus
);

    opcode_t op;
    phase_t  phase;
    logic    halted;
    logic    aluop;

    assign op    = opcode_t'(bus.opcode);
    assign aluop = is_aluop(op);

    phase_counter u_phase_counter (
        .clk    (clk),
        .rst    (rst),
        .opcode (op),
        .phase  (phase),
        .halted (halted)
    );

    assign bus.phase = 3'(phase);

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.halt   = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.data_e = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
        if (halted) begin
            bus.halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR: begin
                    bus.sel = 1'b1;
                end
                INST_FETCH: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    bus.inc_pc = 1'b1;
                    bus.halt   = (op == HLT);
                end
                OP_FETCH: begin
                    bus.rd = aluop;
                end
                ALU_OP: begin
                    bus.rd     = aluop;
                    bus.inc_pc = (op == SKZ) && bus.zero;
                    bus.ld_pc  = (op == JMP);
                    bus.data_e = (op == STO);
                end
                STORE: begin
                    bus.rd     = aluop;
                    bus.ld_ac  = aluop;
                    bus.ld_pc  = (op == JMP);
                    bus.wr     = (op == STO);
                    bus.data_e = (op == STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: expected {phase, controls} pushed per cycle, popped and compared at negedge.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic clk;
    logic rst;
    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;
    logic [11:0] sb[$];
    logic [11:0] exp_v;
    logic [11:0] got_v;

    // Control vector order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
    localparam logic [8:0] C_P0  = 9'b100000000;
    localparam logic [8:0] C_P1  = 9'b110000000;
    localparam logic [8:0] C_P23 = 9'b111000000;
    localparam logic [8:0] C_P4  = 9'b000100000;
    localparam logic [8:0] C_HLT = 9'b000110000;
    localparam logic [8:0] C_HALTED = 9'b000010000;
    localparam logic [8:0] C_NONE = 9'b000000000;

    function automatic logic [11:0] obs();
        return {bus.phase, bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt,
                bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.opcode = 3'(ADD);
        bus.zero   = 1'b0;
        rst = 1'b1;
        #1;
        sb.push_back({3'd0, C_P0});
        exp_v = sb.pop_front();
        got_v = obs();
        tests++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL reset_state got=%b want=%b", got_v, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [8:0] tbl [8];
        tbl = '{C_P0, C_P1, C_P23, C_P23, C_P4, 9'b010000000, 9'b010000000, 9'b010000010};
        bus.opcode = 3'(ADD);
        bus.zero   = 1'b0;
        do_reset();
        for (int p = 0; p < 9; p++) begin
            sb.push_back({3'(p % 8), tbl[p % 8]});
            exp_v = sb.pop_front();
            got_v = obs();
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL add_phase%0d got=%b want=%b", p, got_v, exp_v);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_sto();
        logic [8:0] tbl [8];
        tbl = '{C_P0, C_P1, C_P23, C_P23, C_P4, C_NONE, 9'b000000100, 9'b000000101};
        bus.opcode = 3'(STO);
        bus.zero   = 1'b1;
        do_reset();
        for (int p = 0; p < 8; p++) begin
            sb.push_back({3'(p), tbl[p]});
            exp_v = sb.pop_front();
            got_v = obs();
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL sto_phase%0d got=%b want=%b", p, got_v, exp_v);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_skz();
        logic [8:0] tbl [8];
        for (int z = 1; z >= 0; z--) begin
            tbl = '{C_P0, C_P1, C_P23, C_P23, C_P4, C_NONE,
                    (z == 1) ? 9'b000100000 : C_NONE, C_NONE};
            bus.opcode = 3'(SKZ);
            bus.zero   = 1'(z);
            do_reset();
            for (int p = 0; p < 8; p++) begin
                sb.push_back({3'(p), tbl[p]});
                exp_v = sb.pop_front();
                got_v = obs();
                tests++;
                if (got_v !== exp_v) begin
                    fails++;
                    $display("FAIL skz_z%0d_phase%0d got=%b want=%b", z, p, got_v, exp_v);
                end
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic test_jmp();
        logic [8:0] tbl [8];
        tbl = '{C_P0, C_P1, C_P23, C_P23, C_P4, C_NONE, 9'b000001000, 9'b000001000};
        bus.opcode = 3'(JMP);
        bus.zero   = 1'b1;
        do_reset();
        for (int p = 0; p < 8; p++) begin
            sb.push_back({3'(p), tbl[p]});
            exp_v = sb.pop_front();
            got_v = obs();
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL jmp_phase%0d got=%b want=%b", p, got_v, exp_v);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_halt();
        logic [8:0] tbl [5];
        tbl = '{C_P0, C_P1, C_P23, C_P23, C_HLT};
        bus.opcode = 3'(HLT);
        bus.zero   = 1'b0;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            sb.push_back({3'(p), tbl[p]});
            exp_v = sb.pop_front();
            got_v = obs();
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL hlt_phase%0d got=%b want=%b", p, got_v, exp_v);
            end
            if (p < 4) begin
                @(negedge clk);
                #1;
            end
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.opcode = 3'($urandom_range(0, 7));
            bus.zero   = 1'($urandom_range(0, 1));
            #1;
            sb.push_back({3'd4, C_HALTED});
        end
        exp_v = sb.pop_back();
        sb.delete();
        got_v = obs();
        tests++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL halted_hold got=%b want=%b", got_v, exp_v);
        end
        rst = 1'b1;
        #1;
        sb.push_back({3'd0, C_P0});
        exp_v = sb.pop_front();
        got_v = obs();
        tests++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL halted_rst got=%b want=%b", got_v, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.opcode = 3'(ADD);
        bus.zero   = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        #1;
        sb.push_back({3'd6, 9'b010000000});
        exp_v = sb.pop_front();
        got_v = obs();
        tests++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL async_pre got=%b want=%b", got_v, exp_v);
        end
        #1;
        rst = 1'b1;
        #1;
        sb.push_back({3'd0, C_P0});
        exp_v = sb.pop_front();
        got_v = obs();
        tests++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL async_rst got=%b want=%b", got_v, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_dont_care();
        logic [8:0] tbl [6];
        tbl = '{C_P0, C_P1, C_P23, C_P23, C_P4, 9'b010000000};
        bus.opcode = 3'bx;
        bus.zero   = 1'b1;
        do_reset();
        for (int p = 0; p < 6; p++) begin
            if (p == 3) bus.opcode = 3'(XOR);
            sb.push_back({3'(p), tbl[p]});
            if (p < 4) #1;
            exp_v = sb.pop_front();
            got_v = obs();
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL dontcare_phase%0d got=%b want=%b", p, got_v, exp_v);
            end
            if (p < 3) bus.opcode = 3'($urandom_range(0, 7));
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.opcode = 3'(ADD);
        bus.zero   = 1'b0;
        test_reset();
        test_add();
        test_sto();
        test_skz();
        test_jmp();
        test_halt();
        test_async_reset();
        test_dont_care();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameters: none; widths SHALL be fixed (3-bit opcode, 3-bit phase).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 opcode  input  3  current instruction opcode from the instruction register: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-005 zero  input  1  accumulator-is-zero flag (ALU a_is_zero).
REQ-006 phase  output  3  current phase count.
REQ-007 sel  output  1  address mux select: 1 = program counter, 0 = instruction operand.
REQ-008 rd  output  1  memory read enable.
REQ-009 ld_ir  output  1  instruction register load.
REQ-010 inc_pc  output  1  program counter increment.
REQ-011 halt  output  1  processor halted.
REQ-012 ld_pc  output  1  program counter load (jump).
REQ-013 data_e  output  1  accumulator drive onto data bus.
REQ-014 ld_ac  output  1  accumulator load.
REQ-015 wr  output  1  memory write enable.

Function
REQ-016 Phases SHALL be 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE; phase SHALL advance by 1 per clk while running and wrap from 7 to 0.
REQ-017 Define ALUOP = opcode in {ADD, AND, XOR, LDA}.
REQ-018 Phase 0: sel=1; all other controls 0.
REQ-019 Phase 1: sel=1, rd=1.
REQ-020 Phases 2 and 3: sel=1, rd=1, ld_ir=1.
REQ-021 Phase 4: inc_pc=1; halt=1 if opcode==HLT.
REQ-022 Phase 5: rd=ALUOP.
REQ-023 Phase 6: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
REQ-024 Phase 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); wr=(opcode==STO); data_e=(opcode==STO).
REQ-025 Control outputs SHALL be combinational from the phase register, opcode, zero and the halted flag (zero-cycle decode latency); any control not listed for a phase SHALL be 0.
REQ-026 A registered halted flag SHALL set on the rising edge ending phase 4 when opcode==HLT.
REQ-027 While halted: phase SHALL hold at 4, halt=1, every other control output 0; opcode and zero changes SHALL have no effect; only rst exits.
REQ-028 SKZ with zero=0 and ADD/AND/XOR/LDA with any zero SHALL NOT drive ld_pc; JMP SHALL NOT drive rd or ld_ac.
REQ-029 Opcode X/Z during phases 0-3 SHALL NOT affect outputs (opcode is don't-care there).

Reset
REQ-030 rst asserted at any time, including mid-instruction or while halted, SHALL immediately force phase=0 and halted=0, giving sel=1 and all other controls 0.
REQ-031 First increment SHALL occur on the first rising clk edge after rst deasserts.

Structure
REQ-032 A shared package SHALL hold the opcode enum (HLT..JMP, also used by the ALU) and the phase enum (INST_ADDR..STORE).
REQ-033 The phase counter with halt freeze SHALL be one sub-module, phase_counter; decode SHALL stay in cpu_sequencer.

Verification
REQ-034 Reset then 8 clocks with opcode=ADD -> phase 0..7 then 0; rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7.
REQ-035 opcode=STO -> data_e=1 in phases 6 and 7, wr=1 only in 7, rd=0 in 5-7.
REQ-036 opcode=SKZ with zero=1 -> inc_pc=1 in phases 4 and 6; with zero=0 -> inc_pc=1 in phase 4 only.
REQ-037 opcode=JMP -> ld_pc=1 in phases 6 and 7, ld_ac=0 throughout.
REQ-038 opcode=HLT -> halt=1 in phase 4; after 10 more clocks phase=4, halt=1, other controls 0; pulse rst -> phase=0, halt=0.
REQ-039 rst asserted asynchronously mid-phase 6 (between edges) -> outputs reach phase-0 values before the next clk edge.
